// File: rtl/alu_share_arb_if.sv
// Request/response bundle between the two requesters and alu_share_arb.
// Port i of each 2-bit vector belongs to requester i; rsp_data/rsp_zero are
// shared and qualified by the rsp_valid bit that is set.
interface alu_share_arb_if #(
  parameter int DW = 32,
  parameter int CW = 4
);
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [DW-1:0] req_a0;
  logic [DW-1:0] req_b0;
  logic [CW-1:0] req_ctr0;
  logic [DW-1:0] req_a1;
  logic [DW-1:0] req_b1;
  logic [CW-1:0] req_ctr1;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_zero;

  // requester side
  modport master (
    output req_valid, req_a0, req_b0, req_ctr0, req_a1, req_b1, req_ctr1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero
  );

  // arbiter side
  modport slave (
    input  req_valid, req_a0, req_b0, req_ctr0, req_a1, req_b1, req_ctr1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero
  );
endinterface

// File: rtl/alu_share_arb.sv
// Two-port round-robin arbiter/sequencer sharing one external combinational ALU.
// One operation in flight: IDLE (grant + operand capture) -> EXEC (ALU settles,
// result captured) -> RESP (held until the granted port accepts).
// Optional grant statistics counters are enabled by defining ALU_SHARE_ARB_STATS_EN.
module alu_share_arb #(
  parameter int DW    = 32,
  parameter int CW    = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_share_arb_if.slave   bus,
  output logic [DW-1:0]    alu_in1,
  output logic [DW-1:0]    alu_in2,
  output logic [CW-1:0]    alu_ctr,
  input  logic [DW-1:0]    alu_res,
  input  logic             alu_zero,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  // Only subtract updates the ALU zero flag; every other code reports zero=0.
  localparam logic [CW-1:0] CTR_SUB = CW'(4'b0110);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state, state_nxt;
  logic          ptr;        // port favoured when both request
  logic          gnt_id;     // port owning the in-flight operation
  logic          gnt_sel;    // port that would be granted this cycle
  logic          grant_any;
  logic          rsp_done;
  logic [1:0]    rsp_valid_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_zero_q;

  assign grant_any = |bus.req_valid;
  assign gnt_sel   = (&bus.req_valid) ? ptr : bus.req_valid[1];
  assign rsp_done  = gnt_id ? bus.rsp_ready[1] : bus.rsp_ready[0];

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: one EXEC cycle, then hold RESP until the owner accepts
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output: request accept only on the granted, valid port while idle
  always_comb begin
    bus.req_ready = 2'b00;
    if (state == IDLE && grant_any && !reset) begin
      bus.req_ready = gnt_sel ? 2'b10 : 2'b01;
    end
  end

  // Operand capture at grant, result capture in EXEC, pointer update on completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= 1'b0;
      gnt_id      <= 1'b0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_ctr     <= '0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            gnt_id  <= gnt_sel;
            alu_in1 <= gnt_sel ? bus.req_a1   : bus.req_a0;
            alu_in2 <= gnt_sel ? bus.req_b1   : bus.req_b0;
            alu_ctr <= gnt_sel ? bus.req_ctr1 : bus.req_ctr0;
          end
        end
        EXEC: begin
          rsp_data_q  <= alu_res;
          rsp_zero_q  <= (alu_ctr == CTR_SUB) ? alu_zero : 1'b0;
          rsp_valid_q <= gnt_id ? 2'b10 : 2'b01;
        end
        RESP: begin
          if (rsp_done) begin
            rsp_valid_q <= 2'b00;
            ptr         <= ~gnt_id;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SHARE_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Saturating per-port grant counters, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (state == IDLE && grant_any) begin
      if (gnt_sel) cnt1_q <= sat_inc(cnt1_q);
      else         cnt0_q <= sat_inc(cnt0_q);
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`else
  assign gnt_cnt0 = '0;
  assign gnt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios plus randomized operations,
// checked against a transaction-level model (grant choice, ALU result,
// zero flag, saturating grant counts).
module tb_alu_share_arb;
  localparam int DW    = 32;
  localparam int CW    = 4;
  localparam int CNT_W = 2;

  logic             clk;
  logic             reset;
  logic [DW-1:0]    alu_in1, alu_in2, alu_res;
  logic [CW-1:0]    alu_ctr;
  logic             alu_zero;
  logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;

  alu_share_arb_if #(.DW(DW), .CW(CW)) bus ();

  alu_share_arb #(.DW(DW), .CW(CW), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_ctr  (alu_ctr),
    .alu_res  (alu_res),
    .alu_zero (alu_zero),
    .gnt_cnt0 (gnt_cnt0),
    .gnt_cnt1 (gnt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU semantics: and, or, add, sub, signed slt; others give 0
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // External ALU; its zero flag reflects any zero result, the arbiter must filter
  always_comb begin
    alu_res  = ref_alu(alu_in1, alu_in2, alu_ctr);
    alu_zero = (alu_res == 32'd0);
  end

  int   n_vec = 0;
  int   n_err = 0;
  logic ptr_m = 1'b0;
  int   cnt0_m = 0;
  int   cnt1_m = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input int n);
`ifdef ALU_SHARE_ARB_STATS_EN
    return (n > (1 << CNT_W) - 1) ? 64'((1 << CNT_W) - 1) : 64'(n);
`else
    return 64'(0 * n);
`endif
  endfunction

  // One complete operation: request, check grant, mutate inputs in flight,
  // hold the response for 'hold' cycles, then complete it.
  task automatic do_op(input logic [1:0] v,
                       input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1,
                       input int hold);
    logic        g;
    logic [1:0]  oh;
    logic [31:0] ea, eb, er;
    logic [3:0]  ec;
    logic        ez;
    g  = (v == 2'b01) ? 1'b0 : (v == 2'b10) ? 1'b1 : ptr_m;
    oh = g ? 2'b10 : 2'b01;
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    ec = g ? c1 : c0;
    er = ref_alu(ea, eb, ec);
    ez = (ec == 4'b0110) && (er == 32'd0);

    @(negedge clk);
    bus.req_valid = v;
    bus.req_a0 = a0; bus.req_b0 = b0; bus.req_ctr0 = c0;
    bus.req_a1 = a1; bus.req_b1 = b1; bus.req_ctr1 = c1;
    bus.rsp_ready = 2'b00;
    #1 chk("req_ready_grant", 64'(bus.req_ready), 64'(oh));
    @(posedge clk);
    if (g) cnt1_m++; else cnt0_m++;

    @(negedge clk);
    bus.req_a0 = ~a0; bus.req_b0 = a0 ^ b0 ^ 32'h5a5a_0f0f; bus.req_ctr0 = ~c0;
    bus.req_a1 = ~a1; bus.req_b1 = a1 ^ b1 ^ 32'h1234_5678; bus.req_ctr1 = ~c1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'($urandom_range(0, 3));
    #1 chk("req_ready_exec", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
    chk("rsp_data", 64'(bus.rsp_data), 64'(er));
    chk("rsp_zero", 64'(bus.rsp_zero), 64'(ez));
    chk("alu_in1", 64'(alu_in1), 64'(ea));
    chk("alu_in2", 64'(alu_in2), 64'(eb));
    chk("alu_ctr", 64'(alu_ctr), 64'(ec));

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus.rsp_ready = ~oh;
      bus.req_valid = 2'b11;
      bus.req_b0 = $urandom;
      bus.req_b1 = $urandom;
      #1 chk("req_ready_resp", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("rsp_valid_hold", 64'(bus.rsp_valid), 64'(oh));
      chk("rsp_data_hold", 64'(bus.rsp_data), 64'(er));
      chk("rsp_zero_hold", 64'(bus.rsp_zero), 64'(ez));
    end

    @(negedge clk);
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b11;
    #1 chk("req_ready_done", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("rsp_valid_clear", 64'(bus.rsp_valid), 64'd0);
    ptr_m = ~g;
    chk("gnt_cnt0", 64'(gnt_cnt0), exp_cnt(cnt0_m));
    chk("gnt_cnt1", 64'(gnt_cnt1), exp_cnt(cnt1_m));
  endtask

  function automatic logic [3:0] rnd_ctr();
    case ($urandom_range(0, 5))
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0110;
      4: return 4'b0111;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    return ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
  endfunction

  initial begin
    logic [31:0] ra0, rb0, ra1, rb1;
    reset = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_a0 = 32'd1; bus.req_b0 = 32'd2; bus.req_ctr0 = 4'b0010;
    bus.req_a1 = 32'd3; bus.req_b1 = 32'd4; bus.req_ctr1 = 4'b0010;
    bus.rsp_ready = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rst_rsp_zero", 64'(bus.rsp_zero), 64'd0);
    chk("rst_alu_in1", 64'(alu_in1), 64'd0);
    chk("rst_alu_in2", 64'(alu_in2), 64'd0);
    chk("rst_alu_ctr", 64'(alu_ctr), 64'd0);
    chk("rst_gnt_cnt0", 64'(gnt_cnt0), 64'd0);
    chk("rst_gnt_cnt1", 64'(gnt_cnt1), 64'd0);
    bus.req_valid = 2'b00;
    reset = 1'b0;

    // single-port add, subtract with zero result, signed set-less-than
    do_op(2'b01, 32'd7, 32'd5, 4'b0010, 32'd0, 32'd0, 4'b0000, 0);
    do_op(2'b10, 32'd0, 32'd0, 4'b0000, 32'd9, 32'd9, 4'b0110, 0);
    do_op(2'b10, 32'd0, 32'd0, 4'b0000, 32'd3, 32'd9, 4'b0111, 0);
    // zero result from a non-subtract op must not raise rsp_zero
    do_op(2'b01, 32'hF0, 32'h0F, 4'b0000, 32'd0, 32'd0, 4'b0000, 1);

    // both ports continuously valid: alternating grants
    for (int i = 0; i < 4; i++)
      do_op(2'b11, 32'hF0, 32'h3C, 4'b0000, 32'hF0, 32'h0F, 4'b0001, 0);

    // long response back-pressure with the other port requesting
    do_op(2'b11, 32'd100, 32'd1, 4'b0110, 32'd5, 32'd6, 4'b0010, 5);

    // reset during RESP of a port 1 operation
    @(negedge clk);
    bus.req_valid = 2'b10;
    bus.req_a1 = 32'd11; bus.req_b1 = 32'd22; bus.req_ctr1 = 4'b0010;
    bus.rsp_ready = 2'b00;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(posedge clk);
    #1 chk("rsp_valid_pre_rst", 64'(bus.rsp_valid), 64'b10);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("midrst_alu_in1", 64'(alu_in1), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    ptr_m = 1'b0; cnt0_m = 0; cnt1_m = 0;
    do_op(2'b11, 32'd1, 32'd1, 4'b0010, 32'd2, 32'd2, 4'b0010, 0);
    do_op(2'b11, 32'd1, 32'd1, 4'b0010, 32'd2, 32'd2, 4'b0010, 0);

    // repeated grants to port 0 drive its counter into saturation
    for (int i = 0; i < 5; i++)
      do_op(2'b01, 32'(i), 32'd3, 4'b0010, 32'd0, 32'd0, 4'b0000, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      ra0 = rnd_val(); rb0 = ($urandom_range(0, 3) == 0) ? ra0 : rnd_val();
      ra1 = rnd_val(); rb1 = ($urandom_range(0, 3) == 0) ? ra1 : rnd_val();
      do_op(2'($urandom_range(1, 3)), ra0, rb0, rnd_ctr(), ra1, rb1, rnd_ctr(),
            int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
